// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generation and load-use stall control for the EX-stage ALU muxes.
// Tracks the destinations of the in-flight EX/MEM instructions and registers the mux selects into EX.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_imm_sel,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    logic [REG_AW-1:0] r_ex_dst;
    logic              r_ex_wr;
    logic              r_ex_ld;
    logic [REG_AW-1:0] r_mem_dst;
    logic              r_mem_wr;
    logic [1:0]        r_fwd_a_sel;
    logic [1:0]        r_fwd_b_sel;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic       w_mex_rs;
    logic       w_mex_rt;
    logic       w_mmem_rs;
    logic       w_mmem_rt;
    logic       w_stall;
    logic       w_load;
    logic [1:0] w_next_a;
    logic [1:0] w_next_b;

    // Register 0 is hard-wired to zero, so a write to it is never a real producer.
    assign w_mex_rs  = id_rs_used & r_ex_wr  & (r_ex_dst  == id_rs) & (id_rs != '0);
    assign w_mex_rt  = id_rt_used & r_ex_wr  & (r_ex_dst  == id_rt) & (id_rt != '0);
    assign w_mmem_rs = id_rs_used & r_mem_wr & (r_mem_dst == id_rs) & (id_rs != '0);
    assign w_mmem_rt = id_rt_used & r_mem_wr & (r_mem_dst == id_rt) & (id_rt != '0);

    assign w_stall = id_valid & ~flush & r_ex_ld & (w_mex_rs | w_mex_rt);
    assign w_load  = id_valid & ~w_stall & ~flush;

    always_comb begin
        w_next_a = SEL_RF;
        w_next_b = SEL_RF;
        if (w_mex_rs && !r_ex_ld) begin
            w_next_a = SEL_EX;
        end else if (w_mmem_rs) begin
            w_next_a = SEL_MEM;
        end
        if (id_imm_sel) begin
            w_next_b = SEL_IMM;
        end else if (w_mex_rt && !r_ex_ld) begin
            w_next_b = SEL_EX;
        end else if (w_mmem_rt) begin
            w_next_b = SEL_MEM;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ex_dst    <= '0;
            r_ex_wr     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_mem_dst   <= '0;
            r_mem_wr    <= 1'b0;
            r_fwd_a_sel <= SEL_RF;
            r_fwd_b_sel <= SEL_RF;
            r_stall_cnt <= '0;
        end else begin
            r_mem_dst <= r_ex_dst;
            r_mem_wr  <= r_ex_wr;
            if (w_load) begin
                r_ex_dst    <= id_dst;
                r_ex_wr     <= id_regwrite;
                r_ex_ld     <= id_memread;
                r_fwd_a_sel <= w_next_a;
                r_fwd_b_sel <= w_next_b;
            end else begin
                r_ex_dst    <= '0;
                r_ex_wr     <= 1'b0;
                r_ex_ld     <= 1'b0;
                r_fwd_a_sel <= SEL_RF;
                r_fwd_b_sel <= SEL_RF;
            end
            // Saturate rather than wrap so long runs never read back as few stalls.
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall     = w_stall;
    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, stall-counter saturation run and
// randomized traffic checked against an in-flight-instruction reference model.
module tb_fwd_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 5;

    logic              Clk;
    logic              Rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_imm_sel;
    logic [REG_AW-1:0] id_dst;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_imm_sel(id_imm_sel),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic rst, valid;
        logic [REG_AW-1:0] rs;
        logic rsu;
        logic [REG_AW-1:0] rt;
        logic rtu, imm;
        logic [REG_AW-1:0] dst;
        logic rw, mr, fl;
        logic chk, e_stall;
        logic [1:0] e_a, e_b;
        int e_cnt;
    } vec_t;

    typedef struct {
        logic wr, ld;
        logic [REG_AW-1:0] dst;
    } instr_t;

    vec_t   tbl[33];
    instr_t pipe_q[$];
    logic [1:0] m_a, m_b;
    int m_cnt;
    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(int rst, int v, int rs, int rsu, int rt, int rtu, int imm,
                                int dst, int rw, int mr, int fl,
                                int chk, int es, int ea, int eb, int ec);
        vec_t r;
        r.rst = rst[0]; r.valid = v[0]; r.rs = rs[REG_AW-1:0]; r.rsu = rsu[0];
        r.rt = rt[REG_AW-1:0]; r.rtu = rtu[0]; r.imm = imm[0]; r.dst = dst[REG_AW-1:0];
        r.rw = rw[0]; r.mr = mr[0]; r.fl = fl[0];
        r.chk = chk[0]; r.e_stall = es[0]; r.e_a = ea[1:0]; r.e_b = eb[1:0]; r.e_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Youngest in-flight writer of r: 0 = instruction now in EX, 1 = in MEM, -1 = none.
    function automatic int producer_age(logic [REG_AW-1:0] r, logic used);
        for (int a = 0; a < 2; a++)
            if (used && r != 0 && pipe_q[a].wr && pipe_q[a].dst == r) return a;
        return -1;
    endfunction

    function automatic logic [1:0] sel_for_age(int age);
        if (age == 0) return 2'b01;
        if (age == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        instr_t bub;
        bub.wr = 0; bub.ld = 0; bub.dst = '0;
        pipe_q.delete();
        pipe_q.push_back(bub);
        pipe_q.push_back(bub);
        m_a = 2'b00; m_b = 2'b00; m_cnt = 0;
    endtask

    // One clock: drive, check pre-edge outputs, step through the edge, advance the model.
    task automatic cycle(input vec_t v, input bit use_tbl);
        int age_rs, age_rt;
        logic m_stall, enters;
        instr_t nx;
        Rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
        id_rs_used = v.rsu; id_rt_used = v.rtu; id_imm_sel = v.imm; id_dst = v.dst;
        id_regwrite = v.rw; id_memread = v.mr; flush = v.fl;
        #1;
        age_rs  = producer_age(v.rs, v.rsu);
        age_rt  = producer_age(v.rt, v.rtu);
        m_stall = v.valid && !v.fl && pipe_q[0].ld && (age_rs == 0 || age_rt == 0);
        if (v.chk) begin
            if (use_tbl) begin
                check("stall", int'(stall), int'(v.e_stall));
                check("fwd_a_sel", int'(fwd_a_sel), int'(v.e_a));
                check("fwd_b_sel", int'(fwd_b_sel), int'(v.e_b));
                check("stall_cnt", int'(stall_cnt), v.e_cnt);
            end else begin
                check("rnd_stall", int'(stall), int'(m_stall));
                check("rnd_fwd_a", int'(fwd_a_sel), int'(m_a));
                check("rnd_fwd_b", int'(fwd_b_sel), int'(m_b));
                check("rnd_cnt", int'(stall_cnt), m_cnt);
            end
        end
        @(posedge Clk);
        if (v.rst) begin
            model_reset();
        end else begin
            enters = v.valid && !m_stall && !v.fl;
            if (m_stall && m_cnt < (2**CNT_W - 1)) m_cnt++;
            nx.wr = enters ? v.rw : 1'b0;
            nx.ld = enters ? v.mr : 1'b0;
            nx.dst = enters ? v.dst : '0;
            m_a = enters ? sel_for_age(age_rs) : 2'b00;
            m_b = !enters ? 2'b00 : (v.imm ? 2'b11 : sel_for_age(age_rt));
            pipe_q.push_front(nx);
            void'(pipe_q.pop_back());
        end
        #1;
    endtask

    initial begin
        vec_t v;
        model_reset();
        Rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_imm_sel = 0; id_dst = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        @(posedge Clk); #1;

        //            rst v rs u rt u im dst rw mr fl  chk st a b cnt
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 1, 2, 1, 0,  3, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 3, 1, 2, 1, 0,  4, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 1, 1, 2, 1, 0,  3, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 1, 3, 1, 0,  6, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 2, 0);
        tbl[9]  = mk(0, 1, 1, 1, 2, 1, 0,  3, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 1, 1, 3, 1, 1,  7, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 3, 0);
        tbl[13] = mk(0, 1, 1, 1, 0, 0, 0,  5, 1, 1, 0,  1, 0, 0, 0, 0);
        tbl[14] = mk(0, 1, 5, 1, 2, 1, 0,  6, 1, 0, 0,  1, 1, 0, 0, 0);
        tbl[15] = mk(0, 1, 5, 1, 2, 1, 0,  6, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 2, 0, 1);
        tbl[17] = mk(0, 1, 1, 1, 2, 1, 0,  7, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[18] = mk(0, 1, 1, 1, 2, 1, 0,  7, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[19] = mk(0, 1, 7, 1, 2, 1, 0,  8, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[20] = mk(0, 1, 1, 1, 2, 1, 0,  0, 1, 0, 0,  1, 0, 1, 0, 1);
        tbl[21] = mk(0, 1, 0, 1, 0, 1, 0,  9, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 1);
        tbl[23] = mk(0, 1, 1, 1, 0, 0, 0,  5, 1, 1, 0,  1, 0, 0, 0, 1);
        tbl[24] = mk(0, 1, 5, 1, 0, 0, 0,  6, 1, 0, 1,  1, 0, 0, 0, 1);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 1);
        tbl[26] = mk(0, 1, 6, 1, 0, 0, 0, 10, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[27] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 1);
        tbl[28] = mk(0, 1, 1, 1, 0, 0, 0,  5, 1, 1, 0,  1, 0, 0, 0, 1);
        tbl[29] = mk(1, 1, 5, 1, 0, 0, 0,  6, 1, 0, 0,  1, 1, 0, 0, 1);
        tbl[30] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[31] = mk(0, 1, 5, 1, 0, 0, 0, 11, 1, 0, 0,  1, 0, 0, 0, 0);
        tbl[32] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0);

        for (int i = 0; i < 33; i++) cycle(tbl[i], 1'b1);

        // Self-dependent load held in ID: one stall every other cycle, enough to saturate.
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        v = mk(0, 1, 5, 1, 0, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * (2**CNT_W + 3) + 2; i++) cycle(v, 1'b0);
        check("stall_cnt_saturated", int'(stall_cnt), 2**CNT_W - 1);

        for (int i = 0; i < 800; i++) begin
            v.rst   = ($urandom_range(0, 49) == 0);
            v.valid = ($urandom_range(0, 4) != 0);
            v.rs    = REG_AW'($urandom_range(0, 3));
            v.rt    = REG_AW'($urandom_range(0, 3));
            v.rsu   = $urandom_range(0, 3) != 0;
            v.rtu   = $urandom_range(0, 3) != 0;
            v.imm   = ($urandom_range(0, 3) == 0);
            v.dst   = REG_AW'($urandom_range(0, 3));
            v.rw    = $urandom_range(0, 3) != 0;
            v.mr    = ($urandom_range(0, 2) == 0);
            v.fl    = ($urandom_range(0, 7) == 0);
            v.chk   = (i > 0);
            cycle(v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit select codes that drive the EX-stage ALU operand muxes (Mux4to1 instances for operand A and operand B) in the 5-stage pipeline.
- Tracks destination-register state of the in-flight EX and MEM instructions, computes forwarding in ID, and registers the selects into EX.
- Detects load-use hazards, asserts a one-cycle stall, inserts a bubble and counts stalls for performance monitoring.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous reset, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_AW  source register A.
- id_rt  input  REG_AW  source register B.
- id_rs_used  input  1  instruction reads rs.
- id_rt_used  input  1  instruction reads rt.
- id_imm_sel  input  1  operand B is the immediate.
- id_dst  input  REG_AW  destination register.
- id_regwrite  input  1  instruction writes id_dst.
- id_memread  input  1  instruction is a load.
- flush  input  1  branch/jump taken; ID instruction is squashed.
- stall  output  1  combinational; hold PC and IF/ID, bubble into EX.
- fwd_a_sel  output  2  registered select for operand-A mux.
- fwd_b_sel  output  2  registered select for operand-B mux.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding:
  - 00 = ID/EX register-file value.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB write-back data.
  - 11 = immediate; operand B only, never produced for A.
- Internal tracker registers:
  - EX slot {ex_dst, ex_wr, ex_ld}.
  - MEM slot {mem_dst, mem_wr}.
- Tracker update, each cycle:
  - MEM slot <= EX slot.
  - EX slot <= ID fields if id_valid & !stall & !flush; otherwise bubble (wr=0, ld=0, dst=0).
- Match definitions:
  - Register 0 never matches.
  - match_ex(r) = used & ex_wr & (ex_dst==r) & (r!=0).
  - match_mem(r) = used & mem_wr & (mem_dst==r) & (r!=0).
- Stall logic:
  - stall = id_valid & !flush & ex_ld & (match_ex(rs) | match_ex(rt)).
  - Load-use stall always lasts exactly one cycle. Next cycle the load is in MEM, so the retried instruction sees match_mem and selects 10.
- Next-select for A:
  - 01 if match_ex(rs) & !ex_ld.
  - else 10 if match_mem(rs).
  - else 00.
- Next-select for B:
  - 11 if id_imm_sel.
  - else the same rule as A, applied to rt.
  - EX match has priority over MEM match.
- Select registers:
  - Load next-select when the EX slot loads a real instruction.
  - Load 00 when a bubble is inserted.
  - Latency: decode in cycle t, selects valid throughout cycle t+1.
- WB-stage writes need no forwarding: the register file writes before it reads.
- flush and stall in the same cycle:
  - flush wins; stall=0.
  - Bubble inserted; stall_cnt not incremented.
- stall_cnt: +1 on every cycle with stall=1; saturates at all-ones; does not wrap.
- Reset (synchronous, active-high):
  - All tracker fields, fwd_a_sel, fwd_b_sel and stall_cnt go to 0.
  - stall reads 0 the cycle after Rst because ex_ld=0.
  - Rst mid-stall: the bubble and stall are discarded; no forward to stale destinations afterwards.

Test Plan:
- add r3 (ID, regwrite) then sub r4 reading rs=r3 next cycle -> fwd_a_sel=01 in sub's EX cycle, stall=0.
- add r3 ; nop ; or reading rt=r3 -> fwd_b_sel=10 in or's EX cycle; with id_imm_sel=1 instead -> fwd_b_sel=11.
- lw r5 then add reading rs=r5 -> stall=1 for exactly one cycle; fwd_a_sel=00 during bubble, then 10 when add is in EX; stall_cnt 0->1.
- Two writers to r7 back-to-back, then reader of r7 -> fwd_a_sel=01 (EX priority); writer to r0 followed by reader of r0 -> fwd_a_sel=00.
- lw r5 then dependent add with flush=1 same cycle -> stall=0, bubble, stall_cnt unchanged; Rst asserted during a stall -> all outputs 0 next cycle.
- Force 2^CNT_W+3 load-use stalls -> stall_cnt holds at 0xFFFF.
